// File: rtl/alu_seq.sv
// Micro-sequencer driving the nibble-serial 8-bit ALU: operand load, low pass, high pass, then result/flags.
// Optional INC/DEC opcodes are enabled by defining ALU_SEQ_INCDEC_EN.
module alu_seq (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] opc,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic       busy,
   output logic       done,
   output logic       ill,
   output logic [7:0] result,
   output logic [3:0] flags,
   output logic [7:0] alu_op,
   output logic [1:0] alu_la,
   output logic [1:0] alu_lb,
   output logic [1:0] alu_oe,
   output logic [2:0] alu_rsv,
   output logic       alu_ne,
   output logic       alu_ci,
   output logic       alu_l,
   output logic       alu_h,
   input  logic [7:0] alu_res,
   input  logic       alu_carry,
   input  logic       alu_zero
);

   // state | meaning
   // IDLE  | waiting for start, ALU controls quiet
   // LDA   | operand a driven onto the bus into the A latch
   // LDB   | operand b (or 0x01 for INC/DEC) into the B latch
   // LO    | low-nibble pass, carry captured into hc
   // HI    | high-nibble pass with hc as carry-in, result/flags captured at exit
   typedef enum logic [2:0] {IDLE, LDA, LDB, LO, HI} state_t;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_CP  = 4'd7;
   localparam logic [3:0] OP_NEG = 4'd8;
   localparam logic [3:0] OP_INC = 4'd9;
   localparam logic [3:0] OP_DEC = 4'd10;

   localparam logic [1:0] LD_NO   = 2'd0;
   localparam logic [1:0] LD_BUS  = 2'd1;
   localparam logic [1:0] LD_ZERO = 2'd2;
   localparam logic [1:0] OE_NONE = 2'd0;
   localparam logic [1:0] OE_SH   = 2'd1;
   localparam logic [1:0] OE_RES  = 2'd2;

   localparam logic [2:0] RSV_ARITH = 3'b000;
   localparam logic [2:0] RSV_AND   = 3'b100;
   localparam logic [2:0] RSV_OR    = 3'b010;
   localparam logic [2:0] RSV_XOR   = 3'b001;

   state_t     state;
   logic [3:0] opc_q;
   logic [7:0] b_q;
   logic       cin_q;
   logic       hc;

   logic       legal_in;
   logic       is_sub;
   logic       is_neg;
   logic       is_cp;
   logic       ci_lo;
   logic [2:0] rsv_q;
   logic [7:0] ldb_val;
   logic       flag_h;
   logic       flag_c;
   logic [3:0] nxt_flags;

   always_comb begin
`ifdef ALU_SEQ_INCDEC_EN
      legal_in = (opc <= OP_DEC);
`else
      legal_in = (opc <= OP_NEG);
`endif
   end

   // Operation class of the latched opcode, shared by the LO and HI passes.
   always_comb begin
      is_sub  = 1'b0;
      ci_lo   = 1'b0;
      rsv_q   = RSV_ARITH;
      ldb_val = b_q;
      is_neg  = (opc_q == OP_NEG);
      is_cp   = (opc_q == OP_CP);
      case (opc_q)
         OP_ADD: ci_lo = 1'b0;
         OP_ADC: ci_lo = cin_q;
         OP_SUB, OP_CP, OP_NEG: begin
            is_sub = 1'b1;
            ci_lo  = 1'b1;
         end
         OP_SBC: begin
            is_sub = 1'b1;
            ci_lo  = ~cin_q;
         end
         OP_AND: rsv_q = RSV_AND;
         OP_XOR: rsv_q = RSV_XOR;
         OP_OR:  rsv_q = RSV_OR;
`ifdef ALU_SEQ_INCDEC_EN
         OP_INC: begin
            ci_lo   = 1'b0;
            ldb_val = 8'h01;
         end
         OP_DEC: begin
            is_sub  = 1'b1;
            ci_lo   = 1'b1;
            ldb_val = 8'h01;
         end
`endif
         default: ci_lo = 1'b0;
      endcase
   end

   always_comb begin
      flag_h = is_sub ? ~hc : hc;
      flag_c = is_sub ? ~alu_carry : alu_carry;
      case (opc_q)
         OP_AND: begin
            flag_h = 1'b1;
            flag_c = 1'b0;
         end
         OP_OR, OP_XOR: begin
            flag_h = 1'b0;
            flag_c = 1'b0;
         end
`ifdef ALU_SEQ_INCDEC_EN
         OP_INC, OP_DEC: flag_c = cin_q;
`endif
         default: ;
      endcase
      nxt_flags = {alu_zero, is_sub, flag_h, flag_c};
   end

   // Control outputs are registered: each transition loads the controls of the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         opc_q   <= 4'd0;
         b_q     <= 8'd0;
         cin_q   <= 1'b0;
         hc      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ill     <= 1'b0;
         result  <= 8'd0;
         flags   <= 4'd0;
         alu_op  <= 8'd0;
         alu_la  <= LD_NO;
         alu_lb  <= LD_NO;
         alu_oe  <= OE_NONE;
         alu_rsv <= RSV_ARITH;
         alu_ne  <= 1'b0;
         alu_ci  <= 1'b0;
         alu_l   <= 1'b0;
         alu_h   <= 1'b0;
      end else begin
         done    <= 1'b0;
         ill     <= 1'b0;
         alu_op  <= 8'd0;
         alu_la  <= LD_NO;
         alu_lb  <= LD_NO;
         alu_oe  <= OE_NONE;
         alu_rsv <= RSV_ARITH;
         alu_ne  <= 1'b0;
         alu_ci  <= 1'b0;
         alu_l   <= 1'b0;
         alu_h   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (legal_in) begin
                     opc_q  <= opc;
                     b_q    <= b;
                     cin_q  <= cin;
                     busy   <= 1'b1;
                     alu_oe <= OE_SH;
                     // NEG never needs a: it zero-loads the A latch during LO instead.
                     if (opc == OP_NEG) begin
                        state  <= LDB;
                        alu_op <= b;
                        alu_lb <= LD_BUS;
                     end else begin
                        state  <= LDA;
                        alu_op <= a;
                        alu_la <= LD_BUS;
                     end
                  end else begin
                     ill <= 1'b1;
                  end
               end
            end
            LDA: begin
               state  <= LDB;
               alu_op <= ldb_val;
               alu_lb <= LD_BUS;
               alu_oe <= OE_SH;
            end
            LDB: begin
               state   <= LO;
               alu_l   <= 1'b1;
               alu_la  <= is_neg ? LD_ZERO : LD_NO;
               alu_ne  <= is_sub;
               alu_ci  <= ci_lo;
               alu_rsv <= rsv_q;
            end
            LO: begin
               state   <= HI;
               hc      <= alu_carry;
               alu_h   <= 1'b1;
               alu_ci  <= alu_carry;
               alu_oe  <= OE_RES;
               alu_ne  <= is_sub;
               alu_rsv <= rsv_q;
            end
            HI: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
               flags <= nxt_flags;
               if (!is_cp)
                  result <= alu_res;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
